// File: rtl/servo_pwm_scheduler.sv
// Four-channel hobby-servo PWM generator that time-multiplexes one prescaler and one us counter.
// Optional SERVO_SLEW_EN limits how far each pulse width may move per frame.
module servo_pwm_scheduler #(
    parameter int TICK_DIV = 50,
    parameter int SLOT_US  = 5000,
    parameter int MIN_US   = 500,
    parameter int MAX_US   = 2500,
    parameter int STEP_US  = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [12:0] i_servo0,
    input  logic [12:0] i_servo1,
    input  logic [12:0] i_servo2,
    input  logic [12:0] i_servo3,
    output logic [3:0]  o_pwm,
    output logic [1:0]  o_slot,
    output logic        o_frame_start,
    output logic        o_busy
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int US_W  = ($clog2(SLOT_US) > 13) ? $clog2(SLOT_US) : 13;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(SLOT_US - 1);
    localparam logic [12:0]      MIN_W    = 13'(MIN_US);
    localparam logic [12:0]      MAX_W    = 13'(MAX_US);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    if (MAX_US >= SLOT_US || MIN_US > MAX_US || STEP_US < 1 || TICK_DIV < 1) begin : g_bad_cfg
        $error("servo_pwm_scheduler: inconsistent timing parameters");
    end

    logic [0:0]       state;
    logic [PRE_W-1:0] presc;
    logic [US_W-1:0]  us_cnt;
    logic [3:0][12:0] target;
    logic [3:0][12:0] shadow;
    logic [3:0][12:0] shadow_next;
    logic [3:0]       pwm_next;
    logic             tick;
    logic             slot_wrap;
    logic             frame_wrap;
    logic             frame_load;

    assign target     = {i_servo3, i_servo2, i_servo1, i_servo0};
    assign tick       = (presc == PRE_LAST);
    assign slot_wrap  = tick && (us_cnt == US_LAST);
    assign frame_wrap = slot_wrap && (o_slot == 2'd3);
    assign frame_load = i_enable && ((state == ST_IDLE) || frame_wrap);

    function automatic logic [12:0] clamp_width(input logic [12:0] w);
        logic [12:0] res;
        if (w == 13'd0)     res = 13'd0;
        else if (w < MIN_W) res = MIN_W;
        else if (w > MAX_W) res = MAX_W;
        else                res = w;
        return res;
    endfunction

`ifdef SERVO_SLEW_EN
    localparam logic [12:0] STEP_W = 13'(STEP_US);

    // Cleared by reset so the first frame after reset jumps straight to its targets.
    logic primed;

    function automatic logic [12:0] slew_width(input logic [12:0] cur,
                                               input logic [12:0] tgt,
                                               input logic        jump);
        logic [12:0] res;
        if (tgt == 13'd0 || jump)  res = tgt;
        else if (cur == 13'd0)     res = MIN_W;
        else if (tgt > cur)        res = (tgt - cur > STEP_W) ? cur + STEP_W : tgt;
        else                       res = (cur - tgt > STEP_W) ? cur - STEP_W : tgt;
        return res;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)           primed <= 1'b0;
        else if (frame_load) primed <= 1'b1;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            shadow_next[k] = slew_width(shadow[k], clamp_width(target[k]), !primed);
        end
    end
`else
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            shadow_next[k] = clamp_width(target[k]);
        end
    end
`endif

    // NOTE: every bit of a combinational output gets a default before any condition, so no latch is inferred.
    always_comb begin
        pwm_next = '0;
        if (state == ST_RUN) begin
            for (int k = 0; k < 4; k++) begin
                if (o_slot == 2'(k) && us_cnt < US_W'(shadow[k])) pwm_next[k] = 1'b1;
            end
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            presc         <= '0;
            us_cnt        <= '0;
            shadow        <= '0;
            o_pwm         <= '0;
            o_slot        <= '0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_frame_start <= frame_load;
            o_pwm         <= pwm_next;
            if (frame_load) shadow <= shadow_next;

            case (state)
                ST_IDLE: begin
                    presc  <= '0;
                    us_cnt <= '0;
                    o_slot <= '0;
                    o_busy <= i_enable;
                    if (i_enable) state <= ST_RUN;
                end
                default: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) us_cnt <= slot_wrap ? '0 : us_cnt + 1'b1;
                    // Slot index wraps 3 -> 0 on its own; a frame only ends after slot 3 completes.
                    if (slot_wrap) begin
                        o_slot <= o_slot + 1'b1;
                        if (frame_wrap && !i_enable) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Scoreboard bench for servo_pwm_scheduler: stimulus queues expected frame starts and pulses,
// a negedge monitor measures them and compares.
module tb_servo_pwm_scheduler;

    localparam int TICK_DIV = 2;
    localparam int SLOT_US  = 3000;
    localparam int SLOT_CYC = SLOT_US * TICK_DIV;
    localparam int KIND_FS    = 0;
    localparam int KIND_PULSE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [12:0] s0, s1, s2, s3;
    logic [3:0]  o_pwm;
    logic [1:0]  o_slot;
    logic        o_frame_start;
    logic        o_busy;

    servo_pwm_scheduler #(
        .TICK_DIV(TICK_DIV),
        .SLOT_US (SLOT_US),
        .MIN_US  (500),
        .MAX_US  (2500),
        .STEP_US (20)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (en),
        .i_servo0     (s0),
        .i_servo1     (s1),
        .i_servo2     (s2),
        .i_servo3     (s3),
        .o_pwm        (o_pwm),
        .o_slot       (o_slot),
        .o_frame_start(o_frame_start),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int servo;
        int value;
        int offset;
    } ev_t;

    ev_t        exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         last_fs     = 0;
    int         onehot_bad  = 0;
    int         rise[4];
    logic [3:0] prev_pwm    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_fs(input int interval);
        ev_t e;
        e.kind = KIND_FS; e.servo = 0; e.value = interval; e.offset = 0;
        exp_q.push_back(e);
    endtask

    task automatic expect_pulse(input int servo, input int cycles, input int offset);
        ev_t e;
        e.kind = KIND_PULSE; e.servo = servo; e.value = cycles; e.offset = offset;
        exp_q.push_back(e);
    endtask

    // Monitor: frame starts and completed pulses are popped from the queue in time order.
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (!$onehot0(o_pwm)) onehot_bad++;
        if (o_frame_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_frame_start: got frame start, want none (cyc=%0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_fs", KIND_FS, e.kind);
                if (e.value >= 0) check("frame_interval", cyc - last_fs, e.value);
            end
            last_fs = cyc;
        end
        for (int k = 0; k < 4; k++) begin
            if (o_pwm[k] === 1'b1 && !prev_pwm[k]) begin
                rise[k] = cyc;
            end else if (o_pwm[k] !== 1'b1 && prev_pwm[k]) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_pulse: got pulse on servo %0d, want none (cyc=%0d)", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_pulse", KIND_PULSE, e.kind);
                    check("pulse_servo", k, e.servo);
                    check("pulse_width", cyc - rise[k], e.value);
                    check("pulse_offset", rise[k] - last_fs, e.offset);
                end
            end
        end
        prev_pwm = (o_pwm === 4'bxxxx) ? 4'b0000 : o_pwm;
    end

    initial begin
        bit found;
        rst = 1'b1; en = 1'b1;
        s0 = 13'd1500; s1 = 13'd0; s2 = 13'd0; s3 = 13'd0;
        repeat (3) @(negedge clk);
        check("reset_pwm", o_pwm, 4'b0000);
        check("reset_slot", o_slot, 2'd0);
        check("reset_frame_start", o_frame_start, 1'b0);
        check("reset_busy", o_busy, 1'b0);

        // Frame 1: only servo 0 at 1500 us.
        expect_fs(-1);
        expect_pulse(0, 1500 * TICK_DIV, 1);
        rst = 1'b0;
        @(negedge clk);                                   // s = 0
        check("fs1_pulse", o_frame_start, 1'b1);
        check("fs1_busy", o_busy, 1'b1);
        check("fs1_slot", o_slot, 2'd0);
        check("fs1_pwm", o_pwm, 4'b0000);
        @(negedge clk);                                   // s = 1
        check("f1_pwm_start", o_pwm, 4'b0001);

        // Mid-frame target changes only affect frame 2.
        repeat (99) @(negedge clk);                       // s = 100
        s0 = 13'd2000; s1 = 13'd100; s2 = 13'd8000; s3 = 13'd0;
        expect_fs(4 * SLOT_CYC);
`ifdef SERVO_SLEW_EN
        expect_pulse(0, 1520 * TICK_DIV, 1);
        expect_pulse(1, 500 * TICK_DIV, SLOT_CYC + 1);
        expect_pulse(2, 500 * TICK_DIV, 2 * SLOT_CYC + 1);
`else
        expect_pulse(0, 2000 * TICK_DIV, 1);
        expect_pulse(1, 500 * TICK_DIV, SLOT_CYC + 1);
        expect_pulse(2, 2500 * TICK_DIV, 2 * SLOT_CYC + 1);
`endif
        repeat (5899) @(negedge clk);                     // s = 5999
        check("slot0_last", o_slot, 2'd0);
        check("slot0_last_pwm", o_pwm, 4'b0000);
        @(negedge clk);                                   // s = 6000
        check("slot1_first", o_slot, 2'd1);

        repeat (18000) @(negedge clk);                    // s = 24000
        check("fs2_pulse", o_frame_start, 1'b1);
        check("fs2_slot", o_slot, 2'd0);
        check("fs2_busy", o_busy, 1'b1);

        // Stop request during slot 1 of frame 2.
        repeat (6500) @(negedge clk);                     // s = 30500
        check("stop_slot", o_slot, 2'd1);
        en = 1'b0;
        repeat (17499) @(negedge clk);                    // s = 47999
        check("last_cycle_busy", o_busy, 1'b1);
        check("last_cycle_slot", o_slot, 2'd3);
        @(negedge clk);                                   // s = 48000
        check("idle_busy", o_busy, 1'b0);
        check("idle_slot", o_slot, 2'd0);
        check("idle_no_fs", o_frame_start, 1'b0);
        repeat (10) @(negedge clk);                       // s = 48010
        check("idle_stays", o_busy, 1'b0);

        // Restart, then reset in the middle of the servo 0 pulse.
        expect_fs(-1);
        en = 1'b1;
        @(negedge clk);
        check("fs3_pulse", o_frame_start, 1'b1);
        check("fs3_busy", o_busy, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (o_pwm[0] === 1'b1) found = 1'b1;
        end
        check("restart_pulse_seen", found, 1'b1);
        repeat (99) @(negedge clk);
        check("pre_reset_pwm", o_pwm, 4'b0001);
        expect_pulse(0, 100, 1);
        #2 rst = 1'b1; en = 1'b0;
        #1;
        check("async_reset_pwm", o_pwm, 4'b0000);
        check("async_reset_busy", o_busy, 1'b0);
        check("async_reset_slot", o_slot, 2'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_reset_pwm", o_pwm, 4'b0000);
            check("post_reset_fs", o_frame_start, 1'b0);
            check("post_reset_busy", o_busy, 1'b0);
        end

        check("events_outstanding", exp_q.size(), 0);
        check("onehot_violations", onehot_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/servo_pwm_scheduler.md
Name: servo_pwm_scheduler

Overview:
- Turns the four 13-bit servo position words from the data controller into four hobby-servo PWM outputs.
- Uses one shared prescaler and one microsecond slot counter, time-multiplexed so that at most one servo pulse is high at any time (limits peak supply current).
- A 20 ms frame is split into four equal slots, one per servo. Position words are sampled once per frame into shadow registers, so pulses never glitch mid-frame.
- Sits between the data controller and the top-level servo pins.

Parameters:
- TICK_DIV, 50, i_clk cycles per 1 us tick (50 MHz clock).
- SLOT_US, 5000, slot length in us; frame = 4*SLOT_US.
- MIN_US, 500, minimum non-zero pulse width in us.
- MAX_US, 2500, maximum pulse width in us; must be < SLOT_US.
- STEP_US, 20, max width change per frame (used only with the optional feature).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous active-high reset.
- i_enable  input  1  run request; start/stop happen only at frame boundaries.
- i_servo0  input  13  servo 0 target pulse width in us; 0 = servo off.
- i_servo1  input  13  servo 1 target width, same encoding.
- i_servo2  input  13  servo 2 target width.
- i_servo3  input  13  servo 3 target width.
- o_pwm  output  4  PWM outputs; bit k drives servo k.
- o_slot  output  2  index of the slot currently running.
- o_frame_start  output  1  one-cycle pulse when shadows load.
- o_busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, i_rst=1): o_pwm=0, o_slot=0, o_frame_start=0, o_busy=0; shadows=0; prescaler=0; us counter=0; state IDLE. Asserting reset mid-pulse drops o_pwm low immediately.
- Prescaler: counts 0..TICK_DIV-1 and asserts tick on TICK_DIV-1. It is held at 0 in IDLE.
- State machine:
  - IDLE: outputs low. When i_enable=1, go to RUN on the next cycle. That cycle is a frame load: o_frame_start=1, shadows loaded, slot=0, us=0.
  - RUN: us counter advances on each tick, 0..SLOT_US-1. On wrap, slot increments. On wrap from slot 3:
    - if i_enable=1, start a new frame (frame load, slot 0);
    - if i_enable=0, go to IDLE.
- Stopping: deasserting i_enable mid-frame never truncates a frame; all four slots complete.
- Shadow load rule: each target is clamped first. 0 stays 0; 1..MIN_US-1 becomes MIN_US; >MAX_US becomes MAX_US. Compare at 13 bits, unsigned.
- PWM output (registered):
  - o_pwm[k]=1 iff state=RUN, slot=k, us<shadow_k.
  - Only one bit may ever be high.
  - The pulse lasts exactly shadow_k*TICK_DIV cycles and starts 1 cycle after slot entry.
  - A width of 0 gives no pulse.
- o_slot and o_busy are registered. o_busy=1 throughout RUN, including the frame-load cycle.
- Inputs change freely. Only values present on the frame-load cycle affect that frame.
- i_enable high during reset is ignored. The first frame starts on the first cycle after i_rst falls.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: at each frame load, every shadow moves toward its clamped target by at most STEP_US.
  - If the target is 0, the shadow goes to 0 immediately (servo off).
  - Moving from 0 to non-zero starts at MIN_US, then slews.
  - After reset, the first frame jumps directly to the clamped targets.
- Undefined: shadows load the clamped target directly.

Test Plan (TICK_DIV=2, SLOT_US=3000, MIN 500, MAX 2500, STEP 20):
- Reset, then i_enable=1, servo0=1500, servo1..3=0:
  - o_frame_start pulses once;
  - o_pwm[0] is high for exactly 3000 cycles, starting 1 cycle after the load;
  - o_pwm[3:1] stays 0;
  - the next o_frame_start comes 24000 cycles later.
- Clamping: servo1=100 gives a 1000-cycle pulse; servo2=8000 gives a 5000-cycle pulse; servo3=0 gives no pulse. Check that o_pwm is one-hot-or-zero at every cycle.
- Change servo0 from 1500 to 2000 mid-frame: the current frame pulse stays at 3000 cycles; the next frame's pulse is 4000 cycles.
- Drop i_enable during slot 1: slots 2 and 3 still run; o_busy falls after slot 3 wraps; no further o_frame_start.
- Assert i_rst while o_pwm[0] is high: o_pwm=0 in the same cycle (asynchronous); all outputs stay 0 after release until i_enable is seen.
- SERVO_SLEW_EN defined:
  - servo0=1500 steady, then a step to 1600: successive frame pulses are 1520, 1540, … 1600 us (×2 cycles each).
  - A step to 0: the next frame has no pulse.
